// File: rtl/mux41_scan_ctrl.sv
// mux41_scan_ctrl: steps a 4:1 mux select through enabled channels, samples y per channel
// after a settle time and hands the assembled snapshot downstream over valid/ready.
module mux41_scan_ctrl #(
  parameter int SETTLE_CYC = 1,
  parameter bit AUTO_RUN   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] ch_mask,
  input  logic       y_in,
  output logic [1:0] s,
  output logic [3:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy
);
  localparam int CW = $clog2(SETTLE_CYC) + 1;
  localparam logic [CW-1:0] CNT_RLD = CW'(SETTLE_CYC - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [3:0] dout_q, dout_d, mask_q, mask_d, shadow_q, shadow_d, shadow_m, higher;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, busy_q, busy_d, sample, handshake, go;
  function automatic logic [1:0] lowest(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
  assign sample    = cnt_q == '0;
  assign higher    = mask_q & (4'b1110 << s_q);
  assign handshake = state_q == HOLD && dout_ready;
  // an auto-run restart with an empty mask detours through IDLE so valid drops for one cycle
  assign go = (state_q == IDLE && (start || AUTO_RUN)) ||
              (handshake && AUTO_RUN && ch_mask != '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      mask_q   <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = go ? (ch_mask != '0 ? SETTLE : HOLD) : IDLE;
      SETTLE:  state_d = (sample && higher == '0) ? HOLD : SETTLE;
      HOLD:    state_d = dout_ready ? (go ? SETTLE : IDLE) : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    s_d      = s_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    shadow_m = shadow_q;
    shadow_m[s_q] = y_in;
    if (state_q == SETTLE && !sample) cnt_d = cnt_q - CW'(1);
    if (state_q == SETTLE && sample) begin
      shadow_d = shadow_m;
      if (higher != '0) begin
        s_d   = lowest(higher);
        cnt_d = CNT_RLD;
      end else begin
        dout_d  = shadow_m;
        valid_d = 1'b1;
      end
    end
    if (handshake) valid_d = 1'b0;
    if (go) begin
      mask_d   = ch_mask;
      shadow_d = '0;
      cnt_d    = CNT_RLD;
      if (ch_mask != '0) s_d = lowest(ch_mask);
      else begin
        dout_d  = '0;
        valid_d = 1'b1;
      end
    end
    busy_d = state_d != IDLE;
  end
  assign s          = s_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_mux41_scan_ctrl.sv
// tb_mux41_scan_ctrl: random and directed scans on three configurations, checked against
// an abstract model (expected word = i & mask, select trace and latency from the mask).
module tb_mux41_scan_ctrl;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, dout_ready = 1'b0;
  logic [3:0] ch_mask = '0, i_v = '0;
  logic [1:0] s_w [3];
  logic [3:0] dout_w [3];
  logic v_w [3], b_w [3], y_w [3];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) assign y_w[k] = i_v[s_w[k]];
  mux41_scan_ctrl #(.SETTLE_CYC(1), .AUTO_RUN(1'b0)) dut0 (.clk(clk), .rst(rst), .start(start),
    .ch_mask(ch_mask), .y_in(y_w[0]), .s(s_w[0]), .dout(dout_w[0]), .dout_valid(v_w[0]),
    .dout_ready(dout_ready), .busy(b_w[0]));
  mux41_scan_ctrl #(.SETTLE_CYC(3), .AUTO_RUN(1'b0)) dut1 (.clk(clk), .rst(rst), .start(start),
    .ch_mask(ch_mask), .y_in(y_w[1]), .s(s_w[1]), .dout(dout_w[1]), .dout_valid(v_w[1]),
    .dout_ready(dout_ready), .busy(b_w[1]));
  mux41_scan_ctrl #(.SETTLE_CYC(1), .AUTO_RUN(1'b1)) dut2 (.clk(clk), .rst(rst), .start(start),
    .ch_mask(ch_mask), .y_in(y_w[2]), .s(s_w[2]), .dout(dout_w[2]), .dout_valid(v_w[2]),
    .dout_ready(dout_ready), .busy(b_w[2]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input int d);
    start = 1'b0;
    dout_ready = 1'b1;
    for (int c = 0; c < 40 && (b_w[d] || v_w[d]); c++) step();
    check("drain_idle", {30'd0, b_w[d], v_w[d]}, 0);
  endtask
  task automatic scan(input int d, input logic [3:0] iv, input logic [3:0] mk, input int hold,
                      input string tag);
    logic [1:0] seq [$];
    int sc, lat;
    sc = d == 1 ? 3 : 1;
    drain(d);
    for (int k = 0; k < 4; k++) if (mk[k]) repeat (sc) seq.push_back(2'(k));
    lat = seq.size() + 1;
    i_v = iv;
    ch_mask = mk;
    start = 1'b1;
    dout_ready = 1'($urandom);
    for (int e = 1; e <= lat; e++) begin
      step();
      start = ($urandom % 4) == 0;
      ch_mask = 4'($urandom);
      dout_ready = 1'($urandom);
      if (e < lat) begin
        check({tag, "_s"}, s_w[d], seq[e-1]);
        check({tag, "_valid_early"}, v_w[d], 0);
        check({tag, "_busy"}, b_w[d], 1);
      end
    end
    check({tag, "_dout"}, dout_w[d], iv & mk);
    check({tag, "_valid"}, v_w[d], 1);
    dout_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      start = 1'($urandom);
      check({tag, "_hold_dout"}, dout_w[d], iv & mk);
      check({tag, "_hold_valid"}, v_w[d], 1);
    end
    start = 1'b0;
    dout_ready = 1'b1;
    step();
    check({tag, "_valid_drop"}, v_w[d], 0);
    dout_ready = 1'b0;
    repeat (2) begin
      step();
      check({tag, "_no_second"}, {v_w[d], b_w[d]}, 0);
    end
  endtask
  initial begin
    logic pv;
    logic [3:0] m;
    int last, nr;
    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < 3; d++) begin
      check("reset_s", s_w[d], 0);
      check("reset_dout", dout_w[d], 0);
      check("reset_valid_busy", {v_w[d], b_w[d]}, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    scan(0, 4'b1001, 4'b1111, 0, "t1");
    scan(0, 4'b1111, 4'b0101, 0, "t2");
    scan(1, 4'b0110, 4'b1111, 0, "t3");
    scan(0, 4'b1100, 4'b1011, 6, "t4");
    scan(0, 4'b1111, 4'b0000, 2, "mask0");
    scan(1, 4'b1010, 4'b1000, 1, "t3_single");
    for (int t = 0; t < 24; t++) scan(int'($urandom % 2), 4'($urandom), 4'($urandom),
                                      int'($urandom % 5), "rand");
    drain(0);
    i_v = 4'b1010;
    ch_mask = 4'hF;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    check("rst_pre_s", s_w[0], 2);
    #2 rst = 1'b1;
    #1;
    check("rst_async_s", s_w[0], 0);
    check("rst_async_dout", dout_w[0], 0);
    check("rst_async_vb", {v_w[0], b_w[0]}, 0);
    step();
    rst = 1'b0;
    scan(0, 4'b0011, 4'b1111, 0, "rst_after");
    ch_mask = 4'b0000;
    start = 1'b0;
    dout_ready = 1'b1;
    repeat (8) step();
    pv = v_w[2];
    for (int k = 0; k < 10; k++) begin
      step();
      check("auto0_toggle", v_w[2], !pv);
      if (v_w[2]) check("auto0_dout", dout_w[2], 0);
      pv = v_w[2];
    end
    for (int r = 0; r < 2; r++) begin
      m = r == 0 ? 4'hF : 4'($urandom_range(1, 15));
      ch_mask = m;
      i_v = 4'($urandom);
      repeat (12) step();
      pv = v_w[2];
      last = -1;
      nr = 0;
      for (int e = 0; e < 30; e++) begin
        step();
        if (v_w[2] && !pv) begin
          check("auto_dout", dout_w[2], i_v & m);
          if (last >= 0) check("auto_period", e - last, $countones(m) + 1);
          last = e;
          nr++;
        end
        pv = v_w[2];
      end
      check("auto_rises", nr >= 3, 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
